// File: rtl/cs_pkg.sv
// Shared types and constants for the writable control-store loader.
package cs_pkg;

  localparam int CS_ADDR_W = 13;
  localparam int CS_WORD_W = 64;

  localparam logic [CS_ADDR_W-1:0] CS_PROM_BASE = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_ADVANCE
  } cs_state_e;

endpackage

// File: rtl/cs_ucode_pack.sv
// Packs four 16-bit halfwords into one microword.
// The quarter index selects which quarter the next halfword lands in.
module cs_ucode_pack
  import cs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [15:0]          hw,
  output logic [CS_WORD_W-1:0] word,
  output logic                 last
);

  logic [1:0]           q_q, q_d;
  logic [CS_WORD_W-1:0] word_q, word_d;
  logic [3:0]           qsel;

  always_comb begin
    qsel = 4'b0000;
    unique case (q_q)
      2'd0: qsel = 4'b0001;
      2'd1: qsel = 4'b0010;
      2'd2: qsel = 4'b0100;
      2'd3: qsel = 4'b1000;
      default: qsel = 4'b0000;
    endcase
  end

  always_comb begin
    word_d = word_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_en && qsel[i]) begin
        word_d[16*i +: 16] = hw;
      end
    end
    q_d = q_q;
    if (clr) begin
      q_d = 2'd0;
    end else if (wr_en) begin
      q_d = q_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= 2'd0;
      word_q <= '0;
    end else begin
      q_q    <= q_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  assign last = (q_q == 2'd3);

endmodule

// File: rtl/cs_ucode_loader.sv
// Microcode loader: halfword stream in, one control-store write per
// packed 64-bit microword out, at consecutive addresses.
module cs_ucode_loader
  import cs_pkg::*;
#(
  parameter int ADDR_W = CS_ADDR_W,
  parameter int WORD_W = CS_WORD_W
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_12_0,
  input  logic [ADDR_W-1:0] COUNT_12_0,
  input  logic [15:0]       HW_15_0,
  input  logic              HW_VALID,
  output logic              HW_READY,
  output logic [ADDR_W-1:0] LUA_12_0,
  output logic [WORD_W-1:0] CSBITS_WR,
  output logic [3:0]        WW_3_0_n,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [ADDR_W:0] PROM_LIM =
    (ADDR_W+1)'(CS_PROM_BASE);

  cs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              hw_ready_q, hw_ready_d;
  logic [3:0]        ww_q, ww_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              pk_wr;
  logic              q_clr;
  logic              q_last;
  logic              cnt_zero;
  logic              cnt_last;
  logic              range_err;
  logic [ADDR_W:0]   last_addr;
  logic [CS_WORD_W-1:0] pk_word;

  assign xfer     = HW_VALID && (state_q == ST_COLLECT);
  assign pk_wr    = xfer && !ABORT;
  assign cnt_zero = (COUNT_12_0 == '0);
  assign cnt_last = (cnt_q == ADDR_W'(1));

  // Last address computed one bit wider so a carry into the PROM half shows.
  assign last_addr = {1'b0, BASE_12_0} + {1'b0, COUNT_12_0}
                   - (ADDR_W+1)'(1);
  assign range_err = !cnt_zero && (last_addr >= PROM_LIM);

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START && !range_err && !cnt_zero) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (xfer && q_last) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ABORT ? ST_IDLE : ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (ABORT || cnt_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    q_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (range_err) begin
            err_d = 1'b1;
          end else if (cnt_zero) begin
            done_d = 1'b1;
          end else begin
            addr_d = BASE_12_0;
            cnt_d  = COUNT_12_0;
            q_clr  = 1'b1;
          end
        end
      end
      ST_ADVANCE: begin
        q_clr = 1'b1;
        if (ABORT) begin
          err_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
          done_d = cnt_last;
        end
      end
      default: begin
        if (ABORT) begin
          err_d = 1'b1;
          q_clr = 1'b1;
        end
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    hw_ready_d = (state_d == ST_COLLECT);
    busy_d     = (state_d != ST_IDLE);
    ww_d       = (state_d == ST_WRITE) ? 4'b0000 : 4'b1111;
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      hw_ready_q <= 1'b0;
      ww_q       <= 4'b1111;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      hw_ready_q <= hw_ready_d;
      ww_q       <= ww_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  cs_ucode_pack u_pack (
    .clk   (sysclk),
    .rst_n (sys_rst_n),
    .clr   (q_clr),
    .wr_en (pk_wr),
    .hw    (HW_15_0),
    .word  (pk_word),
    .last  (q_last)
  );

  assign HW_READY  = hw_ready_q;
  assign WW_3_0_n  = ww_q;
  assign LUA_12_0  = addr_q;
  assign CSBITS_WR = WORD_W'(pk_word);
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule
